program_dump: RTL and testbench
===============================

# program_dump

Program-memory readback block. It streams a requested number of bytes out of program memory as 8N1 UART frames, starting at byte address 0, so the host can verify an image it has just flashed. It sits beside the fetch stage, shares the byte-wide read side of program memory, and drives the board UART TX pin. It includes its own bit-level serializer and baud counter.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200).
- MEM_BYTES, default 1024: program memory size in bytes; upper bound on dump length.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- dump_start, input, 1: single-cycle request to begin a dump; sampled only in IDLE.
- dump_length, input, 32: number of bytes to send; sampled together with dump_start.
- mem_read_address, output, 32: byte address presented to program memory, registered.
- mem_read_data, input, 8: program memory byte; valid one cycle after the address.
- uart_tx, output, 1: serial line, idle high.
- busy, output, 1: high from the cycle after an accepted dump_start until the end of the last stop bit.
- done, output, 1: one-cycle pulse when a dump completes, including zero-length dumps.

## Operation
- Reset values: uart_tx=1, busy=0, done=0, mem_read_address=0, state IDLE, baud and bit counters 0.
- Length latch: length_reg = min(dump_length, MEM_BYTES), unsigned compare.
- States:
  - IDLE: on dump_start, latch the length and set address=0.
    - If the latched length is 0: pulse done next cycle, stay IDLE, busy stays 0.
    - Otherwise: busy=1, go to FETCH.
  - FETCH: mem_read_address holds the current address for one cycle, then go to LOAD.
  - LOAD: capture mem_read_data into the shift register, drive uart_tx=0, clear the baud counter, go to START.
  - START: hold the start bit for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit 7 go to STOP.
  - STOP: drive uart_tx=1 for CLKS_PER_BIT cycles. At the end:
    - If bytes remain: address+1, go to FETCH.
    - Otherwise: busy=0, done=1 for one cycle, go to IDLE.
- Byte count: a 32-bit remaining-count register, decremented once per completed stop bit; no wrap.
- dump_start while busy is ignored, with no effect on the length or the address.
- Reset mid-frame aborts the dump: uart_tx returns high on the next edge, no done pulse, and the partial byte is discarded.
- uart_tx and mem_read_address are registered outputs, so there are no combinational glitches on the pin.

## Timing
- Edge E0 samples dump_start. Then:
  - E0: FETCH, mem_read_address=0.
  - E1: memory data is valid.
  - E2: uart_tx falls (start bit).
- Start-to-first-edge latency is 2 cycles.
- Each bit lasts exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
- Inter-byte gap: 2 extra idle-high cycles (FETCH+LOAD) between the end of a stop bit and the next start bit. Byte period = 10*CLKS_PER_BIT + 2.
- Total dump of N bytes: 2 + N*(10*CLKS_PER_BIT) + (N-1)*2 cycles from E0 until busy falls. done is asserted in the first cycle busy is low.
- Zero-length dump: done is high for the single cycle after E0; uart_tx never leaves 1.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at bit boundaries. CLKS_PER_BIT must be ≥2.

## Test plan
Use CLKS_PER_BIT=4 and MEM_BYTES=16; the memory model returns (addr*17+3)&0xFF.
- Reset, then idle 20 cycles -> uart_tx=1, busy=0, done=0, mem_read_address=0 throughout.
- dump_start with dump_length=1 -> uart_tx falls 2 cycles after the start edge. Line reads 0,1,1,0,0,0,0,0,0,1, each held 4 cycles (byte 0x03 LSB first). busy falls and done pulses at cycle 42.
- dump_length=3 -> decoded bytes 0x03, 0x14, 0x25; mem_read_address steps 0,1,2; exactly 2 idle-high cycles between frames; a single done pulse.
- dump_length=0 -> done high for exactly 1 cycle, busy never rises, uart_tx stays 1.
- dump_length=100 -> clamped to 16 bytes; the last byte is (15*17+3)&0xFF=0x02. A dump_start pulsed mid-dump is ignored and no extra bytes are sent.
- rst asserted during DATA bit 3 of byte 1 -> uart_tx=1 and busy=0 on the next edge, no done pulse. A new dump_length=1 request then restarts from address 0.

Source files
------------

// File: rtl/program_dump.sv
// Program-memory readback: streams the first N bytes of program memory out of
// the board UART pin as 8N1 frames so the host can verify a freshly flashed image.
module program_dump #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MEM_BYTES    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_start,
    input  logic [31:0] dump_length,
    output logic [31:0] mem_read_address,
    input  logic [7:0]  mem_read_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]       MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q,     state_d;
    logic [31:0]       addr_q,      addr_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [7:0]        shift_q,     shift_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic [BAUD_W-1:0] baud_q,      baud_d;
    logic              tx_q,        tx_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic [31:0] clamped_len;
    logic        baud_last;

    // Never read past the end of program memory, whatever the host asks for.
    assign clamped_len = (dump_length > MEM_LIMIT) ? MEM_LIMIT : dump_length;
    assign baud_last   = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    addr_d      = '0;
                    remaining_d = clamped_len;
                    if (clamped_len == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                shift_d = mem_read_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Shift first so bit 0 of the register always mirrors the pin.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (remaining_q != 32'd0) begin
                        remaining_d = remaining_q - 32'd1;
                    end
                    if (remaining_q > 32'd1) begin
                        addr_d  = addr_q + 32'd1;
                        state_d = S_FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_read_address = addr_q;
    assign uart_tx          = tx_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_program_dump.sv
// Self-checking bench for program_dump: a UART receiver decodes frames and
// compares them against a scoreboard filled when each dump is requested.
module tb_program_dump;

    localparam int C      = 4;
    localparam int MB     = 16;
    localparam int PERIOD = 10 * C + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_start;
    logic [31:0] dump_length;
    logic [31:0] mem_read_address;
    logic [7:0]  mem_read_data;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] sb_q[$];
    int         frames_rx       = 0;
    int         last_stop_cyc   = 0;
    bit         prev_stop_valid = 1'b0;

    program_dump #(
        .CLKS_PER_BIT(C),
        .MEM_BYTES   (MB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dump_start      (dump_start),
        .dump_length     (dump_length),
        .mem_read_address(mem_read_address),
        .mem_read_data   (mem_read_data),
        .uart_tx         (uart_tx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_fn(input logic [31:0] a);
        logic [31:0] v;
        v = (a * 32'd17 + 32'd3) & 32'hFF;
        return v[7:0];
    endfunction

    always @(posedge clk) mem_read_data <= mem_fn(mem_read_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // UART receiver: samples mid-bit on the falling clock edge.
    initial begin : rx
        bit         active;
        int         rx_cyc;
        logic [7:0] rx_byte;
        logic [7:0] exp_b;
        active  = 1'b0;
        rx_cyc  = 0;
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active          = 1'b0;
                prev_stop_valid = 1'b0;
            end else if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1'b1;
                    rx_cyc = 0;
                    if (prev_stop_valid)
                        check("gap", 32'(cyc - last_stop_cyc), 32'(C / 2 + 2));
                end
            end else begin
                rx_cyc++;
                if (rx_cyc == C / 2) begin
                    check("start_bit", {31'd0, uart_tx}, 32'd0);
                end else if (rx_cyc == 9 * C + C / 2) begin
                    check("stop_bit", {31'd0, uart_tx}, 32'd1);
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("byte", {24'd0, rx_byte}, {24'd0, exp_b});
                    end
                    frames_rx++;
                    last_stop_cyc   = cyc;
                    prev_stop_valid = 1'b1;
                    active          = 1'b0;
                end else if ((rx_cyc % C) == C / 2) begin
                    rx_byte[(rx_cyc / C) - 1] = uart_tx;
                end
            end
        end
    end

    // Expected line level k cycles after the accepted-start edge of an n-byte dump.
    function automatic logic exp_line(input int k, input int n, input int end_k);
        int b, p, j;
        logic [7:0] byte_v;
        if (k >= end_k) return 1'b1;
        b = k / PERIOD;
        p = k % PERIOD;
        if (b >= n || p < 2) return 1'b1;
        j = (p - 2) / C;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        byte_v = mem_fn(32'(b));
        return byte_v[j - 1];
    endfunction

    task automatic start_dump(input logic [31:0] len);
        @(negedge clk);
        dump_start      = 1'b1;
        dump_length     = len;
        prev_stop_valid = 1'b0;
        @(posedge clk);
        #1 dump_start = 1'b0;
    endtask

    task automatic run_dump(input logic [31:0] len, input int mid_k);
        int n, end_k, busy_hi, busy_fall, done_cnt, done_k, tx_fall, line_bad, addr_bad, f0;
        n       = (len > 32'(MB)) ? MB : int'(len);
        end_k   = (n == 0) ? 0 : 2 + n * 10 * C + (n - 1) * 2;
        busy_hi = 0; busy_fall = -1; done_cnt = 0; done_k = -1; tx_fall = -1;
        line_bad = 0; addr_bad = 0;
        f0 = frames_rx;
        for (int b = 0; b < n; b++) sb_q.push_back(mem_fn(32'(b)));
        start_dump(len);
        for (int k = 0; k <= end_k + 6; k++) begin
            @(negedge clk);
            if (k == mid_k) begin
                dump_start  = 1'b1;
                dump_length = 32'd3;
            end else if (k == mid_k + 1) begin
                dump_start = 1'b0;
            end
            if (busy) busy_hi++;
            else if (busy_fall < 0) busy_fall = k;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (!uart_tx && tx_fall < 0) tx_fall = k;
            if (uart_tx !== exp_line(k, n, end_k)) line_bad++;
            if (k < end_k && (k % PERIOD) == 0 && mem_read_address !== 32'(k / PERIOD)) addr_bad++;
        end
        dump_start = 1'b0;
        check("busy_cycles", 32'(busy_hi), 32'(end_k));
        check("busy_fall", 32'(busy_fall), 32'(end_k));
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_k), 32'(end_k));
        check("tx_fall", 32'(tx_fall), (n == 0) ? 32'hFFFF_FFFF : 32'd2);
        check("line_pattern_bad_cycles", 32'(line_bad), 32'd0);
        check("addr_steps_bad", 32'(addr_bad), 32'd0);
        check("frames", 32'(frames_rx - f0), 32'(n));
        check("sb_left", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic abort_dump();
        int f0, bad;
        f0 = frames_rx;
        sb_q.push_back(mem_fn(32'd0));
        sb_q.push_back(mem_fn(32'd1));
        start_dump(32'd2);
        // Byte 1 start bit begins at k=44, so k=61 lies inside data bit 3.
        for (int k = 0; k <= 61; k++) @(negedge clk);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'd0, uart_tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_addr", mem_read_address, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy || !uart_tx) bad++;
        end
        check("abort_quiet_bad", 32'(bad), 32'd0);
        check("abort_frames", 32'(frames_rx - f0), 32'd1);
        sb_q.delete();
    endtask

    initial begin
        int bad;
        rst         = 1'b1;
        dump_start  = 1'b0;
        dump_length = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({uart_tx, busy, done} !== 3'b100 || mem_read_address !== 32'd0) bad++;
        end
        check("idle_after_reset_bad", 32'(bad), 32'd0);

        run_dump(32'd1, -10);
        run_dump(32'd3, -10);
        run_dump(32'd0, -10);
        run_dump(32'd100, 100);
        abort_dump();
        run_dump(32'd1, -10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
